// File: rtl/dmem_responder.sv
// dmem_responder: word-wide data RAM responder with sub-word read-modify-write and error responses
module dmem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 16384,
  parameter              INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam logic [2:0] LB = 3'd0, LH = 3'd1, LW = 3'd2, LBU = 3'd3, LHU = 3'd4, SH = 3'd6, SW = 3'd7;
  localparam int IW = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN = 32'(4 * DEPTH_WORDS);
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
  state_t        state;
  logic [2:0]    op_q;
  logic [IW-1:0] idx_q;
  logic [1:0]    lane_q;
  logic [31:0]   wdata_q;
  logic [31:0]   word_q;
  logic [31:0]   mem [DEPTH_WORDS];
  logic [31:0]   off, rd, sh, ld, mask, merged;
  logic          bad, store_q;
  always_comb begin
    off     = req_addr - BASE_ADDR;
    bad     = (req_addr < BASE_ADDR) || (off >= SPAN) ||
              ((req_op == LH || req_op == LHU || req_op == SH) && req_addr[0]) ||
              ((req_op == LW || req_op == SW) && req_addr[1:0] != 2'b00);
    store_q = op_q[2] & |op_q[1:0];
    rd      = mem[idx_q];
    sh      = rd >> {lane_q, 3'b000};
    ld      = op_q == LB  ? {{24{sh[7]}}, sh[7:0]} :
              op_q == LH  ? {{16{sh[15]}}, sh[15:0]} :
              op_q == LBU ? {24'b0, sh[7:0]} :
              op_q == LHU ? {16'b0, sh[15:0]} : sh;
    mask    = op_q == SW ? 32'hFFFF_FFFF :
              op_q == SH ? 32'h0000_FFFF << {lane_q, 3'b000} :
                           32'h0000_00FF << {lane_q, 3'b000};
    merged  = (word_q & ~mask) | ((wdata_q << {lane_q, 3'b000}) & mask);
  end
  always_ff @(posedge clk)
    if (state == WRITE && !rst) mem[idx_q] <= merged;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      op_q      <= '0;
      idx_q     <= '0;
      lane_q    <= '0;
      wdata_q   <= '0;
      word_q    <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          op_q      <= req_op;
          idx_q     <= off[IW+1:2];
          lane_q    <= req_addr[1:0];
          wdata_q   <= req_wdata;
          req_ready <= 1'b0;
          rsp_rdata <= '0;
          rsp_err   <= bad;
          rsp_valid <= bad;
          state     <= bad ? RESP : (req_op == SW ? WRITE : READ);
        end
        READ: begin
          word_q <= rd;
          if (!store_q) begin
            rsp_rdata <= ld;
            rsp_valid <= 1'b1;
          end
          state <= store_q ? WRITE : RESP;
        end
        WRITE: begin
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
